// File: rtl/lives_digit_renderer.sv
// rtl/lives_digit_renderer.sv - three-digit decimal lives counter drawn from the 8x16 font ROM
module lives_digit_renderer #(
    parameter logic [9:0] X0 = 10'd16,
    parameter logic [9:0] Y0 = 10'd16
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [9:0]  value,
    input  logic        load,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [7:0]  font_data,
    output logic [10:0] font_addr,
    output logic        pixel_on,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state, state_nxt;
    logic [9:0]  bin;
    logic [11:0] bcd;
    logic [3:0]  cnt;
    logic        pending;
    logic [9:0]  pend_val;
    logic [3:0]  hund, tens, ones;

    logic [9:0]  sat_value;
    logic [11:0] bcd_adj;

    function automatic logic [3:0] adj3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    assign sat_value = (value > 10'd999) ? 10'd999 : value;
    assign bcd_adj   = {adj3(bcd[11:8]), adj3(bcd[7:4]), adj3(bcd[3:0])};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = SHIFT;
            SHIFT:   if (cnt == 4'd9) state_nxt = DONE;
            DONE:    state_nxt = (load || pending) ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // A load landing in DONE is newer than any pending value, so it goes first.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bin      <= '0;
            bcd      <= '0;
            cnt      <= '0;
            pending  <= 1'b0;
            pend_val <= '0;
            hund     <= '0;
            tens     <= '0;
            ones     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        bin <= sat_value;
                        bcd <= '0;
                        cnt <= '0;
                    end
                end
                SHIFT: begin
                    bcd <= {bcd_adj[10:0], bin[9]};
                    bin <= {bin[8:0], 1'b0};
                    cnt <= cnt + 4'd1;
                    if (load) begin
                        pending  <= 1'b1;
                        pend_val <= sat_value;
                    end
                end
                DONE: begin
                    hund    <= bcd[11:8];
                    tens    <= bcd[7:4];
                    ones    <= bcd[3:0];
                    pending <= 1'b0;
                    bcd     <= '0;
                    cnt     <= '0;
                    if (load)         bin <= sat_value;
                    else if (pending) bin <= pend_val;
                end
                default: ;
            endcase
        end
    end

    logic       in_box;
    logic [4:0] dx;
    logic [3:0] row;
    logic [1:0] slot;
    logic [3:0] digit;
    logic       blank;
    logic [2:0] col_q;
    logic       lit_q;

    assign in_box = (DrawX >= X0) && (DrawX < X0 + 10'd24) &&
                    (DrawY >= Y0) && (DrawY < Y0 + 10'd16);
    assign dx     = 5'(DrawX - X0);
    assign row    = 4'(DrawY - Y0);
    assign slot   = dx[4:3];

    always_comb begin
        digit = ones;
        blank = 1'b0;
        case (slot)
            2'd0: begin digit = hund; blank = (hund == 4'd0); end
            2'd1: begin digit = tens; blank = (hund == 4'd0) && (tens == 4'd0); end
            default: digit = ones;
        endcase
    end

    // Stage 1 issues the ROM address; stage 2 picks the bit out of the returned row.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            font_addr <= '0;
            col_q     <= '0;
            lit_q     <= 1'b0;
            pixel_on  <= 1'b0;
        end else begin
            font_addr <= (in_box && !blank) ? {3'b000, digit, row} : 11'd0;
            col_q     <= dx[2:0];
            lit_q     <= in_box && !blank;
            pixel_on  <= lit_q && font_data[3'd7 - col_q];
        end
    end

endmodule

// File: tb/tb_lives_digit_renderer.sv
// tb/tb_lives_digit_renderer.sv - randomized and directed checks of lives_digit_renderer against a decimal model
module tb_lives_digit_renderer;

    localparam int X0 = 16;
    localparam int Y0 = 16;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [9:0]  value = '0;
    logic        load = 1'b0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic [7:0]  font_data;
    logic [10:0] font_addr;
    logic        pixel_on;
    logic        busy;

    logic [7:0]  rom [0:2047];
    int          compared = 0;
    int          mismatched = 0;
    int          disp = 0;

    always #5 Clk = ~Clk;
    assign font_data = rom[font_addr];

    lives_digit_renderer #(.X0(10'(X0)), .Y0(10'(Y0))) dut (
        .Clk(Clk), .Reset_n(Reset_n), .value(value), .load(load),
        .DrawX(DrawX), .DrawY(DrawY), .font_data(font_data),
        .font_addr(font_addr), .pixel_on(pixel_on), .busy(busy)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit in_text(input int x, input int y);
        return x >= X0 && x < X0 + 24 && y >= Y0 && y < Y0 + 16;
    endfunction

    function automatic int slot_digit(input int n, input int x);
        int s = (x - X0) / 8;
        if (s == 0) return n / 100;
        if (s == 1) return (n / 10) % 10;
        return n % 10;
    endfunction

    function automatic bit slot_blank(input int n, input int x);
        int s = (x - X0) / 8;
        return (s == 0 && n < 100) || (s == 1 && n < 10);
    endfunction

    function automatic int exp_addr(input int n, input int x, input int y);
        if (!in_text(x, y) || slot_blank(n, x)) return 0;
        return slot_digit(n, x) * 16 + (y - Y0);
    endfunction

    function automatic int exp_pix(input int n, input int x, input int y);
        logic [7:0] b;
        if (!in_text(x, y) || slot_blank(n, x)) return 0;
        b = rom[slot_digit(n, x) * 16 + (y - Y0)];
        return int'(b[7 - ((x - X0) % 8)]);
    endfunction

    task automatic scan(input int y);
        for (int x = X0 - 2; x <= X0 + 25; x++) begin
            DrawX = 10'(x);
            DrawY = 10'(y);
            @(posedge Clk); #1;
            check("scan_addr", 16'(font_addr), 16'(exp_addr(disp, x, y)));
            if (x > X0 - 2) check("scan_pix", 16'(pixel_on), 16'(exp_pix(disp, x - 1, y)));
        end
        @(posedge Clk); #1;
        check("scan_pix_last", 16'(pixel_on), 16'(exp_pix(disp, X0 + 25, y)));
    endtask

    task automatic do_load(input int v);
        int n;
        value = 10'(v);
        load = 1'b1;
        @(posedge Clk); #1;
        load = 1'b0;
        check("busy_after_load", 16'(busy), 16'd1);
        n = 1;
        for (int k = 0; k < 40 && busy; k++) begin
            @(posedge Clk); #1;
            if (busy) n++;
        end
        check("busy_cycles", 16'(n), 16'd11);
        disp = (v > 999) ? 999 : v;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
        rom[0]   = 8'hFF;
        rom[2]   = 8'h7C;
        rom[114] = 8'hFE;
        rom[150] = 8'h7E;

        #2;
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_addr", 16'(font_addr), 16'd0);
        check("rst_pix", 16'(pixel_on), 16'd0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;

        scan(Y0 + 2);
        scan(Y0 + 16);
        scan(Y0 - 1);

        do_load(7);    scan(Y0 + 2);
        do_load(1000); scan(Y0 + 6);
        do_load(1023); scan(Y0 + 6);
        do_load(105);  scan(Y0 + 5);
        do_load(5);    scan(Y0 + 5);

        for (int i = 0; i < 15; i++) begin
            do_load(int'($urandom_range(0, 1023)));
            scan(Y0 + int'($urandom_range(0, 15)));
        end

        // Back-to-back loads: the middle one must be overwritten while pending.
        begin
            int prev;
            int ef;
            do_load(7);
            prev = disp;
            value = 10'd42;
            load = 1'b1;
            @(posedge Clk); #1;
            load = 1'b0;
            DrawX = 10'(X0 + 8);
            DrawY = 10'(Y0);
            for (int c = 1; c <= 25; c++) begin
                load  = (c == 3 || c == 5);
                value = (c == 3) ? 10'd250 : 10'd300;
                @(posedge Clk); #1;
                load = 1'b0;
                check("pend_busy", 16'(busy), 16'(c < 22));
                ef = (c <= 11) ? prev : (c <= 22) ? 42 : 300;
                check("pend_tens_addr", 16'(font_addr), 16'(exp_addr(ef, X0 + 8, Y0)));
            end
            disp = 300;
            scan(Y0 + 9);
        end

        // Reset in the middle of a conversion of 123.
        value = 10'd123;
        load = 1'b1;
        @(posedge Clk); #1;
        load = 1'b0;
        repeat (5) @(posedge Clk);
        #1;
        Reset_n = 1'b0;
        #1;
        disp = 0;
        check("midrst_busy", 16'(busy), 16'd0);
        check("midrst_addr", 16'(font_addr), 16'd0);
        check("midrst_pix", 16'(pixel_on), 16'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge Clk); #1;
            check("midrst_idle", 16'(busy), 16'd0);
        end
        scan(Y0 + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/lives_digit_renderer.md
# lives_digit_renderer

Reads the 8x16 digit font ROM to draw a three-digit decimal counter (player lives) on the VGA raster. Converts a binary value to BCD sequentially, holds the displayed digits, and for each DrawX/DrawY generates the glyph address into the font ROM, then turns the returned row byte into a registered pixel-on flag for the colour mapper.

## Interface
- X0, 10'd16: left pixel column of the 24x16 text box.
- Y0, 10'd16: top pixel row of the text box.
- Clk  in  1  system/pixel clock; all state on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- value  in  10  binary count to display.
- load  in  1  single-cycle request to convert and display value.
- DrawX  in  10  current raster column.
- DrawY  in  10  current raster row.
- font_data  in  8  row byte returned combinationally by the font ROM for font_addr.
- font_addr  out  11  glyph row address: digit*16 + row.
- pixel_on  out  1  registered: current pixel is a lit glyph pixel.
- busy  out  1  conversion in progress.

## Operation
- Converter FSM states: IDLE, SHIFT, DONE.
  - IDLE: on load, capture min(value, 999) into 10-bit shift register, clear 12-bit BCD accumulator, iteration count 0, go SHIFT.
  - SHIFT: each cycle add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by 1; after the 10th iteration go DONE.
  - DONE: copy BCD nibbles to display registers hund/tens/ones; if pending set, capture pending value, clear pending, go SHIFT; else go IDLE.
- load while not IDLE: store value (saturated) in pending register, set pending; later loads overwrite it (last wins). load in the IDLE cycle is never lost.
- busy = (state != IDLE).
- Display registers change only in DONE; the raster always sees a complete old or new number.
- Text box: X0 <= DrawX < X0+24, Y0 <= DrawY < Y0+16. Inside: dx = DrawX-X0, digit slot = dx[4:3] (0 = hundreds, 1 = tens, 2 = ones), col = dx[2:0], row = (DrawY-Y0)[3:0].
- Leading-zero suppression: hundreds blank if 0; tens blank if hundreds and tens both 0; ones always drawn.
- Lit pixel = in box, slot not blank, font_data[7-col] == 1.
- Outside box or blank slot: font_addr = 0, pixel_on = 0.

## Timing
- Reset: state IDLE, busy 0, pending 0, hund/tens/ones 0 (displays "0"), font_addr 0, pixel_on 0, shift/BCD/count registers 0.
- Raster pipeline, 2 cycles: DrawX/DrawY sampled at edge N; font_addr, delayed col, in-box and blank flags registered at edge N; ROM returns font_data during cycle N+1; pixel_on registered at edge N+1, so it reflects coordinates presented two edges earlier. Pipeline runs every cycle, independent of busy.
- Conversion: load sampled at edge 0 -> busy 1 after edge 0; SHIFT on edges 1-10; DONE at edge 11 updates digits; busy 0 after edge 11. Total 11 cycles.
- With pending set at DONE: busy stays 1 with no IDLE cycle, and the next result lands 11 edges later.
- Reset_n low mid-conversion: all registers clear immediately; pending value discarded; display returns to "0".
- Arithmetic: BCD adjust per nibble is 4-bit; saturation compare is on the full 10-bit input; address = {3'b0, digit[3:0], row[3:0]}.

## Test plan
- Reset, then DrawX=X0+16..X0+23, DrawY=Y0+2 -> font_addr=2, pixel_on (two cycles later) = 0,1,1,1,1,1,0,0; hundreds and tens slots dark; busy=0.
- load value=7 -> busy high exactly 11 cycles; then ones row 2 at DrawY=Y0+2 gives font_addr=114 and pattern 11111110; slots 0 and 1 give font_addr 0 and pixel_on 0.
- load value=1000 and value=1023 -> display 999; at DrawY=Y0+6, ones slot font_addr=150, pattern 01111110.
- load value=105 -> tens slot drawn as '0'; at DrawY=Y0+5, font_addr=5 (tens) and 85 (ones); also check value=5 blanks hundreds and tens.
- load 42, then load 250 at cycle 3 and load 300 at cycle 5 -> digits show 42 at edge 11 with busy still 1, then 300 at edge 22, busy 0 after; 250 never appears.
- DrawX=X0-1, X0+24, DrawY=Y0+16 -> pixel_on 0; assert Reset_n low at cycle 5 of a conversion of 123 -> busy 0 and display "0" immediately, with no later update.
